// File: rtl/div_scheduler.sv
// Round-robin front end that shares one pipelined restoring divider among NREQ requesters.
// Each accepted op carries a tag down a shift register that matches the divider latency.
module pipelinediv #(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8
) (
  input  logic                clock,
  input  logic [DIVIDEND-1:0] dividend,
  input  logic [DIVISOR-1:0]  divisor,
  output logic [DIVIDEND-1:0] quotient,
  output logic [DIVISOR-1:0]  remainder
);
  localparam int N = DIVIDEND;

  // One quotient bit per stage, MSB first; quotient bits replace consumed dividend bits.
  function automatic logic [DIVISOR+DIVIDEND-1:0] div_step(
    input logic [DIVISOR-1:0]  rem,
    input logic [DIVIDEND-1:0] qd,
    input logic [DIVISOR-1:0]  dsr
  );
    logic [DIVISOR:0]   trial;
    logic [DIVISOR-1:0] diff;
    trial = {rem, qd[DIVIDEND-1]};
    diff  = trial[DIVISOR-1:0] - dsr;
    if (trial >= {1'b0, dsr})
      return {diff, qd[DIVIDEND-2:0], 1'b1};
    return {trial[DIVISOR-1:0], qd[DIVIDEND-2:0], 1'b0};
  endfunction

  logic [DIVISOR-1:0]  rem_p [1:N];
  logic [DIVIDEND-1:0] qd_p  [1:N];
  logic [DIVISOR-1:0]  dsr_p [1:N-1];

  logic [DIVISOR-1:0]  rem_c [0:N-1];
  logic [DIVIDEND-1:0] qd_c  [0:N-1];
  logic [DIVISOR-1:0]  dsr_c [0:N-1];

  always_comb begin
    rem_c[0] = '0;
    qd_c[0]  = dividend;
    dsr_c[0] = divisor;
    for (int s = 1; s < N; s++) begin
      rem_c[s] = rem_p[s];
      qd_c[s]  = qd_p[s];
      dsr_c[s] = dsr_p[s];
    end
  end

  // stage s -> stage s+1
  always_ff @(posedge clock) begin
    for (int s = 0; s < N; s++)
      {rem_p[s+1], qd_p[s+1]} <= div_step(rem_c[s], qd_c[s], dsr_c[s]);
    for (int s = 0; s < N-1; s++)
      dsr_p[s+1] <= dsr_c[s];
  end

  assign quotient  = qd_p[N];
  assign remainder = rem_p[N];
endmodule

module div_scheduler #(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8,
  parameter int NREQ     = 4,
  parameter int LATENCY  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DIVIDEND-1:0] req_dividend,
  input  logic [NREQ*DIVISOR-1:0]  req_divisor,
  output logic [NREQ-1:0]          resp_valid,
  output logic [DIVIDEND-1:0]      resp_quotient,
  output logic [DIVISOR-1:0]       resp_remainder,
  output logic                     resp_dz,
  output logic                     busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gnt_id;
  logic                gnt_any;
  int                  idx;

  logic [DIVIDEND-1:0] dvd_p0;
  logic [DIVISOR-1:0]  dsr_p0;
  logic [DIVIDEND-1:0] div_q;
  logic [DIVISOR-1:0]  div_r;

  logic [LATENCY:0]    tag_v;
  logic [LATENCY:0]    tag_dz;
  logic [PW-1:0]       tag_id [0:LATENCY];
  logic [DIVISOR-1:0]  tag_lo [0:LATENCY];

  // Round-robin search starting at ptr; nothing is granted while in reset.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    gnt_any   = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_any && !reset && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = PW'(idx);
      end
    end
    if (gnt_any)
      req_ready[gnt_id] = 1'b1;
  end

  // issue stage: operand regs and pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr    <= '0;
      dvd_p0 <= '0;
      dsr_p0 <= '0;
    end else if (gnt_any) begin
      ptr    <= (gnt_id == PW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      dvd_p0 <= req_dividend[gnt_id*DIVIDEND +: DIVIDEND];
      dsr_p0 <= req_divisor[gnt_id*DIVISOR +: DIVISOR];
    end
  end

  pipelinediv #(
    .DIVIDEND (DIVIDEND),
    .DIVISOR  (DIVISOR)
  ) u_div (
    .clock     (clock),
    .dividend  (dvd_p0),
    .divisor   (dsr_p0),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // tag pipeline, aligned with the divider stages
  always_ff @(posedge clock) begin
    if (reset)
      tag_v <= '0;
    else
      tag_v <= {tag_v[LATENCY-1:0], gnt_any};
  end

  always_ff @(posedge clock) begin
    tag_dz    <= {tag_dz[LATENCY-1:0],
                  req_divisor[gnt_id*DIVISOR +: DIVISOR] == '0};
    tag_id[0] <= gnt_id;
    tag_lo[0] <= req_dividend[gnt_id*DIVIDEND +: DIVISOR];
    for (int k = 1; k <= LATENCY; k++) begin
      tag_id[k] <= tag_id[k-1];
      tag_lo[k] <= tag_lo[k-1];
    end
  end

  // response stage: divide-by-zero overrides the divider result
  always_ff @(posedge clock) begin
    if (reset || !tag_v[LATENCY]) begin
      resp_valid     <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_dz        <= 1'b0;
    end else begin
      resp_valid <= NREQ'(1) << tag_id[LATENCY];
      if (tag_dz[LATENCY]) begin
        resp_quotient  <= '1;
        resp_remainder <= tag_lo[LATENCY];
        resp_dz        <= 1'b1;
      end else begin
        resp_quotient  <= div_q;
        resp_remainder <= div_r;
        resp_dz        <= 1'b0;
      end
    end
  end

  assign busy = |tag_v;
endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: directed literal cases plus random streaming against
// a cycle-indexed expectation map built from the arbitration and division rules.
module tb_div_scheduler;
  localparam int DVD  = 16;
  localparam int DSR  = 8;
  localparam int NREQ = 4;
  localparam int LAT  = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DVD-1:0] req_dividend;
  logic [NREQ*DSR-1:0] req_divisor;
  logic [NREQ-1:0]     resp_valid;
  logic [DVD-1:0]      resp_quotient;
  logic [DSR-1:0]      resp_remainder;
  logic                resp_dz;
  logic                busy;

  div_scheduler #(.DIVIDEND(DVD), .DIVISOR(DSR), .NREQ(NREQ), .LATENCY(LAT)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .resp_valid     (resp_valid),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .resp_dz        (resp_dz),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int ncyc = 0;
  always @(posedge clock) ncyc <= ncyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, ncyc);
    end
  endtask

  typedef struct packed {
    logic [NREQ-1:0] v;
    logic [DVD-1:0]  q;
    logic [DSR-1:0]  r;
    logic            dz;
  } exp_t;

  // Expected outputs keyed by the cycle count at which they must be visible.
  exp_t expm [int];
  int   mptr  = 0;
  bit   armed = 0;

  always @(negedge clock) begin : cmp
    logic [NREQ-1:0] eg;
    int              g;
    exp_t            e;
    logic            eb;
    logic [DVD-1:0]  dv;
    logic [DSR-1:0]  ds;
    eg = '0;
    g  = 0;
    if (!reset)
      for (int k = 0; k < NREQ; k++)
        if (eg == '0 && req_valid[(mptr + k) % NREQ]) begin
          g = (mptr + k) % NREQ;
          eg[g] = 1'b1;
        end
    chk("req_ready", 32'(req_ready), 32'(eg));
    if (armed) begin
      e = '0;
      if (expm.exists(ncyc)) e = expm[ncyc];
      eb = 1'b0;
      foreach (expm[kk]) if (kk > ncyc) eb = 1'b1;
      chk("resp_valid", 32'(resp_valid), 32'(e.v));
      chk("resp_quotient", 32'(resp_quotient), 32'(e.q));
      chk("resp_remainder", 32'(resp_remainder), 32'(e.r));
      chk("resp_dz", 32'(resp_dz), 32'(e.dz));
      chk("busy", 32'(busy), 32'(eb));
      expm.delete(ncyc);
    end
    if (reset) begin
      expm.delete();
      mptr  = 0;
      armed = 1;
    end else if (eg != '0) begin
      dv   = req_dividend[g*DVD +: DVD];
      ds   = req_divisor[g*DSR +: DSR];
      e    = '0;
      e.v[g] = 1'b1;
      if (ds == 0) begin
        e.q  = '1;
        e.r  = dv[DSR-1:0];
        e.dz = 1'b1;
      end else begin
        e.q = dv / DVD'(ds);
        e.r = DSR'(dv % DVD'(ds));
      end
      expm[ncyc + LAT + 2] = e;
      mptr = (g + 1) % NREQ;
    end
  end

  task automatic directed(input int id, input logic [DVD-1:0] dv, input logic [DSR-1:0] ds,
                          input logic [DVD-1:0] eq, input logic [DSR-1:0] er, input logic edz);
    int lat;
    bit found;
    @(posedge clock); #1;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_dividend[id*DVD +: DVD] = dv;
    req_divisor[id*DSR +: DSR]  = ds;
    @(negedge clock);
    chk("dir_ready", 32'(req_ready), 32'(1 << id));
    @(posedge clock); #1;
    req_valid = '0;
    found = 0;
    lat   = 0;
    for (int i = 0; i < LAT + 6 && !found; i++) begin
      @(negedge clock);
      if (resp_valid != '0) begin
        found = 1;
        lat   = i;
      end
    end
    chk("dir_found", 32'(found), 32'(1));
    if (found) begin
      chk("dir_latency", 32'(lat), 32'(LAT + 1));
      chk("dir_valid", 32'(resp_valid), 32'(1 << id));
      chk("dir_quotient", 32'(resp_quotient), 32'(eq));
      chk("dir_remainder", 32'(resp_remainder), 32'(er));
      chk("dir_dz", 32'(resp_dz), 32'(edz));
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    req_valid = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 4) @(posedge clock);
  endtask

  initial begin
    bit found;
    reset        = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_valid", 32'(resp_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));

    directed(2, 16'd200, 8'd7, 16'd28, 8'd4, 1'b0);
    directed(1, 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1);
    directed(0, 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
    directed(3, 16'd0, 8'd255, 16'd0, 8'd0, 1'b0);
    directed(2, 16'd255, 8'd255, 16'd1, 8'd0, 1'b0);
    directed(1, 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);

    // all four requesting continuously from ptr=0
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*DVD +: DVD] = DVD'(1000 * i + 77);
      req_divisor[i*DSR +: DSR]  = DSR'(i + 3);
    end
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("rr_grant", 32'(req_ready), 32'(1 << (c % NREQ)));
      @(posedge clock);
    end
    #1 req_valid = '0;
    found = 0;
    for (int i = 0; i < LAT + 6 && !found; i++) begin
      @(negedge clock);
      if (resp_valid != '0) found = 1;
    end
    chk("rr_found", 32'(found), 32'(1));
    for (int c = 0; c < 8; c++) begin
      chk("rr_order", 32'(resp_valid), 32'(1 << (c % NREQ)));
      @(negedge clock);
    end
    drain();

    // reset with five ops in flight
    @(posedge clock); #1;
    req_valid = '1;
    repeat (5) @(posedge clock);
    #1;
    req_valid = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clock);
      chk("rst_no_resp", 32'(resp_valid), 32'(0));
      if (i == 0) chk("rst_busy", 32'(busy), 32'(0));
    end
    @(posedge clock); #1;
    req_valid = '1;
    @(negedge clock);
    chk("rst_ptr", 32'(req_ready), 32'(1));
    @(posedge clock); #1;
    req_valid = '0;
    drain();

    // random streaming
    for (int c = 0; c < 10000; c++) begin
      @(posedge clock); #1;
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 7))
          0: req_divisor[i*DSR +: DSR] = '0;
          1: req_divisor[i*DSR +: DSR] = '1;
          2: req_divisor[i*DSR +: DSR] = DSR'(1);
          default: req_divisor[i*DSR +: DSR] = DSR'($urandom);
        endcase
        case ($urandom_range(0, 7))
          0: req_dividend[i*DVD +: DVD] = '0;
          1: req_dividend[i*DVD +: DVD] = '1;
          default: req_dividend[i*DVD +: DVD] = DVD'($urandom);
        endcase
      end
    end
    @(posedge clock); #1;
    req_valid = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
